// File: rtl/ex_data_packetizer_if.sv
// Handshake bundle between the data packetizer, its prefetch FIFO read port
// and the downstream byte-stream sink.
interface ex_data_packetizer_if;
   logic        enable;
   logic        fifo_rd_vld;
   logic [7:0]  fifo_rd_data;
   logic        fifo_rd_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic        out_ready;
   logic        busy;
   logic [15:0] pkt_cnt;

   modport master (
      input  enable, fifo_rd_vld, fifo_rd_data, out_ready,
      output fifo_rd_en, out_valid, out_data, out_sop, out_eop, busy, pkt_cnt
   );

   modport slave (
      output enable, fifo_rd_vld, fifo_rd_data, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_sop, out_eop, busy, pkt_cnt
   );
endinterface

// File: rtl/ex_data_packetizer.sv
// Pops bytes from a prefetch FIFO and frames every PAYLOAD_LEN of them as
// SYNC0 SYNC1 SEQ LEN_HI LEN_LO payload CSUM on a registered valid/ready stream.
module ex_data_packetizer #(
   parameter int unsigned PAYLOAD_LEN = 256,
   parameter logic [7:0]  SYNC0       = 8'hA5,
   parameter logic [7:0]  SYNC1       = 8'h5A
) (
   input  logic                 clk,
   input  logic                 rst,
   ex_data_packetizer_if.master pkt_if
);
   localparam logic [15:0] LEN      = 16'(PAYLOAD_LEN);
   localparam logic [10:0] LAST_IDX = 11'(PAYLOAD_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PAY  = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t      state_q;
   logic [2:0]  hdr_idx_q;
   logic [10:0] pay_cnt_q;
   logic [7:0]  csum_q;
   logic [7:0]  seq_q;
   logic [15:0] pkt_cnt_q;
   logic        out_valid_q;
   logic [7:0]  out_data_q;
   logic        out_sop_q;
   logic        out_eop_q;

   logic        slot_free;
   logic        pop;
   logic [7:0]  hdr_byte_d;

   // Output slot availability, FIFO pop decode and header byte selection
   always_comb begin
      slot_free = !out_valid_q || pkt_if.out_ready;
      if (state_q == ST_PAY) begin
         pop = pkt_if.fifo_rd_vld && slot_free;
      end else begin
         pop = 1'b0;
      end
      case (hdr_idx_q)
         3'd1:    hdr_byte_d = SYNC1;
         3'd2:    hdr_byte_d = seq_q;
         3'd3:    hdr_byte_d = LEN[15:8];
         3'd4:    hdr_byte_d = LEN[7:0];
         default: hdr_byte_d = SYNC0;
      endcase
   end

   // Packet FSM with registered stream outputs; a free slot with nothing to load drains the register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hdr_idx_q   <= 3'd0;
         pay_cnt_q   <= 11'd0;
         csum_q      <= 8'd0;
         seq_q       <= 8'd0;
         pkt_cnt_q   <= 16'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end else begin
         if (slot_free) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (slot_free && pkt_if.enable && pkt_if.fifo_rd_vld) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= SYNC0;
                  out_sop_q   <= 1'b1;
                  hdr_idx_q   <= 3'd1;
                  state_q     <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (slot_free) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= hdr_byte_d;
                  hdr_idx_q   <= hdr_idx_q + 3'd1;
                  if (hdr_idx_q == 3'd4) begin
                     pay_cnt_q <= 11'd0;
                     csum_q    <= 8'd0;
                     state_q   <= ST_PAY;
                  end
               end
            end
            ST_PAY: begin
               if (pop) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= pkt_if.fifo_rd_data;
                  csum_q      <= csum_q + pkt_if.fifo_rd_data;
                  pay_cnt_q   <= pay_cnt_q + 11'd1;
                  if (pay_cnt_q == LAST_IDX) begin
                     state_q <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (slot_free) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= csum_q;
                  out_eop_q   <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_valid_q && pkt_if.out_ready && out_eop_q) begin
                  seq_q     <= seq_q + 8'd1;
                  pkt_cnt_q <= pkt_cnt_q + 16'd1;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign pkt_if.fifo_rd_en = pop;
   assign pkt_if.out_valid  = out_valid_q;
   assign pkt_if.out_data   = out_data_q;
   assign pkt_if.out_sop    = out_sop_q;
   assign pkt_if.out_eop    = out_eop_q;
   assign pkt_if.busy       = (state_q != ST_IDLE);
   assign pkt_if.pkt_cnt    = pkt_cnt_q;
endmodule

// File: tb/tb_ex_data_packetizer.sv
// Bench for ex_data_packetizer: a queue-backed FIFO source and a stream sink,
// with every received packet compared against a packet built from the framing rules.
module tb_ex_data_packetizer;
   localparam int PL = 4;

   typedef logic [7:0] byte_q_t[$];
   typedef logic [9:0] beat_q_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_data_packetizer_if bus();

   ex_data_packetizer #(
      .PAYLOAD_LEN(PL),
      .SYNC0      (8'hA5),
      .SYNC1      (8'h5A)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pkt_if(bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   byte_q_t     fifo_q;
   beat_q_t     rx_q;
   int          rx_pkts = 0;
   int          viol = 0;
   int          ready_mode = 0;
   logic        ready_tog = 1'b0;
   logic        starve = 1'b0;
   logic        rand_starve = 1'b0;
   logic        prev_stall = 1'b0;
   logic [10:0] prev_out = 11'd0;
   int          start_cyc = -1;
   int          sop_cyc = -1;
   int          first_acc = -1;
   int          last_acc = -1;
   int          valid_gap = 0;
   logic [7:0]  exp_seq = 8'd0;
   int          exp_pkts = 0;

   // Reference packet, derived only from the framing rules
   function automatic beat_q_t build_pkt(input logic [7:0] seq, input byte_q_t pay);
      beat_q_t b;
      int sum = 0;
      int len = pay.size();
      b.push_back({2'b10, 8'hA5});
      b.push_back({2'b00, 8'h5A});
      b.push_back({2'b00, seq});
      b.push_back({2'b00, 8'(len / 256)});
      b.push_back({2'b00, 8'(len % 256)});
      foreach (pay[i]) begin
         sum = sum + int'(pay[i]);
         b.push_back({2'b00, pay[i]});
      end
      b.push_back({2'b01, 8'(sum % 256)});
      return b;
   endfunction

   function automatic int first_diff(input beat_q_t a, input beat_q_t b);
      if (a.size() != b.size()) return -2;
      foreach (a[i]) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   function automatic string diff_str(input beat_q_t a, input beat_q_t b, input int d);
      if (d < 0) return $sformatf("size got=%0d required=%0d", a.size(), b.size());
      return $sformatf("beat %0d got=%h required=%h", d, a[d], b[d]);
   endfunction

   function automatic byte_q_t rand_payload();
      byte_q_t p;
      for (int i = 0; i < PL; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   // One clock: drive inputs just after the edge, then sample the settled handshake
   task automatic cycle();
      @(posedge clk);
      #1;
      case (ready_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = 1'($urandom_range(0, 1));
         2: bus.out_ready = 1'b0;
         default: begin
            ready_tog = ~ready_tog;
            bus.out_ready = ready_tog;
         end
      endcase
      if (rand_starve) starve = ($urandom_range(0, 3) == 0);
      bus.fifo_rd_vld  = (fifo_q.size() > 0) && !starve;
      bus.fifo_rd_data = bus.fifo_rd_vld ? fifo_q[0] : 8'($urandom);
      #1;
      cyc++;
      if (bus.fifo_rd_en && !bus.fifo_rd_vld) viol++;
      if (bus.out_valid && !bus.out_ready && bus.fifo_rd_en) viol++;
      if (prev_stall && ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data} != prev_out)) viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
      if (bus.busy && !bus.out_valid) valid_gap++;
      if (!bus.busy && bus.enable && bus.fifo_rd_vld && start_cyc < 0) start_cyc = cyc;
      if (bus.out_valid && bus.out_sop && sop_cyc < 0) sop_cyc = cyc;
      if (bus.fifo_rd_en) void'(fifo_q.pop_front());
      if (bus.out_valid && bus.out_ready) begin
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
         rx_q.push_back({bus.out_sop, bus.out_eop, bus.out_data});
         if (bus.out_eop) rx_pkts++;
      end
   endtask

   task automatic wait_pkts(input int n, input string name);
      int budget = 0;
      while (rx_pkts < n && budget < 3000) begin
         cycle();
         budget++;
      end
      total++;
      if (rx_pkts < n) begin
         bad++;
         $display("FAIL %s_timeout: packets got=%0d required=%0d", name, rx_pkts, n);
      end
      repeat (2) cycle();
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_pkts   = 0;
      start_cyc = -1;
      sop_cyc   = -1;
      first_acc = -1;
      last_acc  = -1;
      valid_gap = 0;
      viol      = 0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data, bus.busy, bus.fifo_rd_en} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b s=%b e=%b d=%h busy=%b rd=%b required all 0",
                  bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data, bus.busy, bus.fifo_rd_en);
      end
      total++;
      if (bus.pkt_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_pkt_cnt: got=%0d required=0", bus.pkt_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [9:0] gold [10];
      beat_q_t g;
      int d;
      gold = '{10'h2A5, 10'h05A, 10'h000, 10'h000, 10'h004,
               10'h001, 10'h002, 10'h003, 10'h004, 10'h10A};
      foreach (gold[i]) g.push_back(gold[i]);
      clear_rx();
      ready_mode = 0;
      bus.enable = 1'b1;
      fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      wait_pkts(1, "basic");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, g);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL basic_stream: %s", diff_str(rx_q, g, d));
      end
      total++;
      if (bus.pkt_cnt !== 16'(exp_pkts)) begin
         bad++;
         $display("FAIL basic_pkt_cnt: got=%0d required=%0d", bus.pkt_cnt, exp_pkts);
      end
      total++;
      if (sop_cyc - start_cyc != 1) begin
         bad++;
         $display("FAIL basic_start_latency: got=%0d required=1", sop_cyc - start_cyc);
      end
      total++;
      if (last_acc - first_acc != PL + 5) begin
         bad++;
         $display("FAIL basic_throughput: span got=%0d required=%0d", last_acc - first_acc, PL + 5);
      end
   endtask

   task automatic test_backpressure();
      beat_q_t exp;
      int d;
      int budget = 0;
      int stall_bad = 0;
      logic [7:0] held;
      clear_rx();
      ready_mode = 3;
      fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp = build_pkt(exp_seq, fifo_q);
      while (rx_q.size() < 6 && budget < 200) begin
         cycle();
         budget++;
      end
      ready_mode = 2;
      cycle();
      held = bus.out_data;
      repeat (4) begin
         cycle();
         if (bus.fifo_rd_en !== 1'b0 || bus.out_data !== held || bus.out_valid !== 1'b1) stall_bad++;
      end
      total++;
      if (stall_bad != 0) begin
         bad++;
         $display("FAIL bp_stall_hold: disturbed cycles got=%0d required=0", stall_bad);
      end
      ready_mode = 3;
      wait_pkts(1, "backpressure");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL bp_stream: %s", diff_str(rx_q, exp, d));
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL bp_protocol: violations got=%0d required=0", viol);
      end
   endtask

   task automatic test_starvation();
      beat_q_t exp;
      byte_q_t pay;
      int d;
      int budget = 0;
      int busy_bad = 0;
      clear_rx();
      ready_mode = 0;
      pay = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp = build_pkt(exp_seq, pay);
      fifo_q = '{8'h01, 8'h02};
      while (fifo_q.size() > 0 && budget < 200) begin
         cycle();
         budget++;
      end
      repeat (10) begin
         cycle();
         if (bus.busy !== 1'b1) busy_bad++;
      end
      total++;
      if (busy_bad != 0 || valid_gap == 0) begin
         bad++;
         $display("FAIL starve_gap: busy-low cycles got=%0d required=0, gap cycles got=%0d required>0",
                  busy_bad, valid_gap);
      end
      fifo_q.push_back(8'h03);
      fifo_q.push_back(8'h04);
      wait_pkts(1, "starvation");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL starve_stream: %s", diff_str(rx_q, exp, d));
      end
      total++;
      if (rx_q.size() != PL + 6 || rx_q[rx_q.size() - 1] !== 10'h10A) begin
         bad++;
         $display("FAIL starve_csum: got size=%0d required csum beat 10a", rx_q.size());
      end
   endtask

   task automatic test_csum_wrap();
      beat_q_t exp;
      int d;
      clear_rx();
      ready_mode = 1;
      fifo_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp = build_pkt(exp_seq, fifo_q);
      wait_pkts(1, "csum_wrap");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL csum_wrap_stream: %s", diff_str(rx_q, exp, d));
      end
      total++;
      if (rx_q.size() != PL + 6 || rx_q[rx_q.size() - 1] !== 10'h1FC) begin
         bad++;
         $display("FAIL csum_wrap_value: got size=%0d required last beat 1fc", rx_q.size());
      end
   endtask

   task automatic test_enable_mid();
      beat_q_t exp;
      int d;
      int budget = 0;
      clear_rx();
      ready_mode = 0;
      fifo_q = rand_payload();
      exp = build_pkt(exp_seq, fifo_q);
      while (rx_q.size() < 1 && budget < 100) begin
         cycle();
         budget++;
      end
      bus.enable = 1'b0;
      wait_pkts(1, "enable_mid");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL enable_mid_stream: %s", diff_str(rx_q, exp, d));
      end
      clear_rx();
      fifo_q = rand_payload();
      exp = build_pkt(exp_seq, fifo_q);
      repeat (20) cycle();
      total++;
      if (rx_q.size() != 0 || bus.busy !== 1'b0 || fifo_q.size() != PL) begin
         bad++;
         $display("FAIL enable_off_hold: got beats=%0d busy=%b fifo=%0d required 0/0/%0d",
                  rx_q.size(), bus.busy, fifo_q.size(), PL);
      end
      bus.enable = 1'b1;
      wait_pkts(1, "enable_resume");
      exp_seq++;
      exp_pkts++;
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL enable_resume_stream: %s", diff_str(rx_q, exp, d));
      end
   endtask

   task automatic test_random();
      beat_q_t exp;
      int d;
      int errs = 0;
      ready_mode  = 1;
      rand_starve = 1'b1;
      for (int p = 0; p < 20; p++) begin
         clear_rx();
         fifo_q = rand_payload();
         exp = build_pkt(exp_seq, fifo_q);
         wait_pkts(1, "random");
         exp_seq++;
         exp_pkts++;
         d = first_diff(rx_q, exp);
         total++;
         if (d != -1 || viol != 0) begin
            bad++;
            errs++;
            if (errs < 4) $display("FAIL random_pkt%0d: %s violations=%0d", p, diff_str(rx_q, exp, d), viol);
         end
      end
      rand_starve = 1'b0;
      starve      = 1'b0;
   endtask

   task automatic test_reset_mid();
      beat_q_t exp;
      int d;
      int budget = 0;
      clear_rx();
      ready_mode = 0;
      fifo_q = rand_payload();
      while (rx_q.size() < 7 && budget < 100) begin
         cycle();
         budget++;
      end
      rst = 1'b1;
      #1;
      total++;
      if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data, bus.busy, bus.fifo_rd_en, bus.pkt_cnt} !== 29'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got v=%b s=%b e=%b d=%h busy=%b rd=%b cnt=%0d required all 0",
                  bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data, bus.busy, bus.fifo_rd_en, bus.pkt_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      fifo_q.delete();
      prev_stall = 1'b0;
      exp_seq  = 8'd0;
      exp_pkts = 0;
      clear_rx();
      fifo_q = rand_payload();
      exp = build_pkt(exp_seq, fifo_q);
      wait_pkts(1, "reset_restart");
      exp_seq++;
      exp_pkts++;
      total++;
      if (rx_q.size() < 3 || rx_q[0] !== 10'h2A5 || rx_q[1] !== 10'h05A || rx_q[2] !== 10'h000) begin
         bad++;
         $display("FAIL reset_restart_hdr: got size=%0d required header 2a5 05a 000", rx_q.size());
      end
      d = first_diff(rx_q, exp);
      total++;
      if (d != -1) begin
         bad++;
         $display("FAIL reset_restart_stream: %s", diff_str(rx_q, exp, d));
      end
   endtask

   task automatic test_seq_wrap();
      beat_q_t exp;
      int d;
      int errs = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      prev_stall = 1'b0;
      exp_seq  = 8'd0;
      exp_pkts = 0;
      ready_mode = 0;
      for (int i = 0; i < 257; i++) begin
         clear_rx();
         fifo_q = rand_payload();
         exp = build_pkt(8'(i), fifo_q);
         wait_pkts(1, "seq_wrap");
         exp_pkts++;
         d = first_diff(rx_q, exp);
         total++;
         if (d != -1) begin
            bad++;
            errs++;
            if (errs < 4) $display("FAIL seq_wrap_pkt%0d: %s", i, diff_str(rx_q, exp, d));
         end
      end
      total++;
      if (bus.pkt_cnt !== 16'd257) begin
         bad++;
         $display("FAIL seq_wrap_pkt_cnt: got=%0d required=257", bus.pkt_cnt);
      end
   endtask

   initial begin
      bus.enable       = 1'b0;
      bus.fifo_rd_vld  = 1'b0;
      bus.fifo_rd_data = 8'd0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_starvation();
      test_csum_wrap();
      test_enable_mid();
      test_random();
      test_reset_mid();
      test_seq_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ex_data_packetizer.md
# ex_data_packetizer

Downstream consumer of the 8-bit prefetch data FIFO in the video capture path. It pops bytes from the FIFO read port and wraps every `PAYLOAD_LEN` bytes into a framed packet: sync word, sequence number, length, payload, then an 8-bit checksum. It presents the packet one byte per beat on a valid/ready stream toward the transmit MAC/UART stage.

## Interface

**Parameters**
- `PAYLOAD_LEN`, default 256: payload bytes per packet. Legal range 1..2048.
- `SYNC0`, default 8'hA5: first header byte.
- `SYNC1`, default 8'h5A: second header byte.

**Ports**
- `clk` in, 1: single clock, shared with the FIFO.
- `rst` in, 1: asynchronous, active-high reset.
- `enable` in, 1: permits a new packet to start. Sampled only in IDLE.
- `fifo_rd_vld` in, 1: FIFO has a byte present on `fifo_rd_data` (prefetch / first-word-fall-through).
- `fifo_rd_data` in, 8: FIFO head byte.
- `fifo_rd_en` out, 1: pops the head byte this cycle. Combinational.
- `out_valid` out, 1: `out_data` holds a valid byte.
- `out_data` out, 8: stream byte.
- `out_sop` out, 1: marks the first byte (`SYNC0`) of a packet.
- `out_eop` out, 1: marks the last byte (checksum) of a packet.
- `out_ready` in, 1: sink accepts the byte when `out_valid && out_ready`.
- `busy` out, 1: high in any state other than IDLE.
- `pkt_cnt` out, 16: count of completed packets. Wraps.

## Operation

- **Packet format**, `PAYLOAD_LEN`+6 bytes in order: `SYNC0`, `SYNC1`, `SEQ[7:0]`, `LEN[15:8]`, `LEN[7:0]`, payload[0..`PAYLOAD_LEN`-1], `CSUM`.
  - `LEN` = `PAYLOAD_LEN` as 16 bits.
  - `CSUM` = sum of the payload bytes mod 256. Header bytes are excluded.
- **Output register**: `out_valid/out_data/out_sop/out_eop` are registered.
  - Define "slot free" = `!out_valid || out_ready`.
  - A new byte loads only when the slot is free.
  - While `out_valid && !out_ready`, all four outputs hold stable.
- **States**:
  - IDLE: if `enable && fifo_rd_vld` and the slot is free, load `SYNC0` with `out_sop=1` and go to HDR with `hdr_idx=1`. Otherwise stay.
  - HDR: on each free slot, load the header byte at `hdr_idx` and increment `hdr_idx`. After loading `LEN[7:0]` (idx 4), go to PAY with `pay_cnt=0` and `csum=0`.
  - PAY: `fifo_rd_en = fifo_rd_vld && slot free`. On a pop:
    - load `fifo_rd_data`;
    - `csum += fifo_rd_data` (8-bit wrap);
    - `pay_cnt++`.
    - After the pop with `pay_cnt == PAYLOAD_LEN-1`, go to CSUM.
    - If `fifo_rd_vld` is low, no byte loads. `out_valid` drops after the current byte is accepted, so gaps inside the payload are legal.
  - CSUM: on a free slot, load `csum` with `out_eop=1` and go to DONE.
  - DONE: when the checksum byte is accepted (`out_valid && out_ready && out_eop`), increment `seq` (8-bit wrap) and `pkt_cnt`, then go to IDLE.
  - `fifo_rd_en` is 0 in every state except PAY.
- **`enable` deasserted mid-packet**: the current packet completes. No new packet starts.
- **`fifo_rd_en`** never asserts while `fifo_rd_vld` is 0, and never asserts while `out_valid && !out_ready`.
- **`pay_cnt`** is 11 bits wide.

## Timing

- **Reset values**: all outputs 0, state IDLE, `seq` 0, `pkt_cnt` 0, `csum` 0.
- **Reset mid-packet**: the partial packet is abandoned with no eop, and the stream restarts from `SEQ=0`.
- **Start latency**: `SYNC0` appears on `out_valid` one cycle after the cycle in which `enable && fifo_rd_vld` is seen in IDLE.
- **Throughput**: with `out_ready=1` and the FIFO never empty, one byte per cycle with no bubbles inside a packet.
- **Gap between packets**: one bubble cycle minimum (DONE→IDLE), so back-to-back packets are separated by at least 1 cycle.
- **Pop-to-output latency**: a FIFO byte popped in cycle N is on `out_data` in cycle N+1.

## Test plan

- **Basic packet**: `PAYLOAD_LEN`=4, FIFO holds 01 02 03 04, `out_ready=1`, `enable=1`.
  - Required stream: A5 5A 00 00 04 01 02 03 04 0A.
  - `out_sop` on A5 only, `out_eop` on 0A only.
  - `pkt_cnt` becomes 1.
- **Backpressure**: same stimulus with `out_ready` toggling 1010… and held low for 5 cycles mid-payload.
  - Bytes are identical and never duplicated or dropped.
  - `fifo_rd_en` stays 0 while stalled.
  - `out_data` is stable during the stall.
- **Starvation**: FIFO supplies 01 02, then goes empty for 10 cycles, then supplies 03 04.
  - `out_valid` has a gap and `busy` stays 1.
  - Same 10-byte packet as the basic case; `CSUM`=0A.
- **Checksum wrap**: payload FF FF FF FF → `CSUM`=FC.
- **Sequence wrap**: run 257 packets.
  - `SEQ` bytes go 00..FF, then 00.
  - `pkt_cnt`=257.
- **Reset mid-payload**: assert `rst` after 2 payload bytes.
  - All outputs go to 0 immediately.
  - The next packet starts with A5 5A 00.
